// File: rtl/arith_pkg.sv
// Shared arithmetic-unit definitions:
// divider state encoding and two's-complement helpers.
package arith_pkg;

  localparam int ARITH_WIDTH = 4;
  localparam int ARITH_MAXW  = 64;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    SIGN = 2'd2,
    DONE = 2'd3
  } div_state_e;

  // Two's-complement negate on a wide, pre-extended operand.
  function automatic logic [ARITH_MAXW-1:0] tc_neg(
    input logic [ARITH_MAXW-1:0] x
  );
    return ~x + ARITH_MAXW'(1);
  endfunction

  // Magnitude of a sign-extended operand; callers truncate the result.
  function automatic logic [ARITH_MAXW-1:0] tc_abs(
    input logic [ARITH_MAXW-1:0] x
  );
    return x[ARITH_MAXW-1] ? tc_neg(x) : x;
  endfunction

endpackage

// File: rtl/udiv_step.sv
// One restoring-division iteration on unsigned magnitudes:
// shift in one dividend bit, trial-subtract, keep or restore.
module udiv_step #(
  parameter int W = 4
) (
  input  logic [W:0] rem_i,
  input  logic       bit_i,
  input  logic [W:0] dvs_i,
  output logic [W:0] rem_o,
  output logic       q_o
);

  logic [W+1:0] sh;
  logic [W+1:0] diff;

  // Partial remainder stays below the divisor, so W+2 bits hold the sign.
  always_comb begin
    sh    = {rem_i, bit_i};
    diff  = sh - {1'b0, dvs_i};
    q_o   = ~diff[W+1];
    rem_o = q_o ? diff[W:0] : sh[W:0];
  end

endmodule

// File: rtl/seq_signed_divider.sv
// Multi-cycle signed divider, one quotient bit per clock.
// Magnitudes are divided, then signs are fixed up in one extra cycle.
module seq_signed_divider
  import arith_pkg::*;
#(
  parameter int WIDTH = ARITH_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             ready,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_by_zero,
  output logic             overflow
);

  localparam int CW = $clog2(WIDTH + 1);

  div_state_e       state_q;
  logic [CW-1:0]    cnt_q;
  logic [WIDTH:0]   pr_q;
  logic [WIDTH:0]   dq_q;
  logic [WIDTH:0]   ds_q;
  logic [WIDTH-1:0] dvd_q;
  logic             q_neg_q;
  logic             dz_q;
  logic             ov_q;

  logic             ready_q;
  logic             done_q;
  logic [WIDTH-1:0] quo_q;
  logic [WIDTH-1:0] rem_q;
  logic             dz_o_q;
  logic             ov_o_q;

  logic [ARITH_MAXW-1:0] dvd_ext;
  logic [ARITH_MAXW-1:0] dvs_ext;
  logic [WIDTH:0]        dvd_mag_d;
  logic [WIDTH:0]        dvs_mag_d;
  logic [WIDTH-1:0]      quo_d;
  logic [WIDTH-1:0]      rem_d;
  logic [WIDTH:0]        pr_d;
  logic                  qbit_d;

  udiv_step #(.W(WIDTH)) u_step (
    .rem_i (pr_q),
    .bit_i (dq_q[WIDTH-1]),
    .dvs_i (ds_q),
    .rem_o (pr_d),
    .q_o   (qbit_d)
  );

  // Operand magnitudes for loading and signed results for the fix-up.
  always_comb begin
    dvd_ext   = {{(ARITH_MAXW-WIDTH){dividend[WIDTH-1]}}, dividend};
    dvs_ext   = {{(ARITH_MAXW-WIDTH){divisor[WIDTH-1]}}, divisor};
    dvd_mag_d = (WIDTH+1)'(tc_abs(dvd_ext));
    dvs_mag_d = (WIDTH+1)'(tc_abs(dvs_ext));
    quo_d     = q_neg_q ? WIDTH'(tc_neg(ARITH_MAXW'(dq_q)))
                        : WIDTH'(dq_q);
    rem_d     = dvd_q[WIDTH-1] ? WIDTH'(tc_neg(ARITH_MAXW'(pr_q)))
                               : WIDTH'(pr_q);
  end

  // Control FSM with datapath registers and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      pr_q    <= '0;
      dq_q    <= '0;
      ds_q    <= '0;
      dvd_q   <= '0;
      q_neg_q <= 1'b0;
      dz_q    <= 1'b0;
      ov_q    <= 1'b0;
      ready_q <= 1'b1;
      done_q  <= 1'b0;
      quo_q   <= '0;
      rem_q   <= '0;
      dz_o_q  <= 1'b0;
      ov_o_q  <= 1'b0;
    end else begin
      done_q <= 1'b0;
      unique case (state_q)
        IDLE, DONE: begin
          if (start) begin
            dvd_q   <= dividend;
            q_neg_q <= dividend[WIDTH-1] ^ divisor[WIDTH-1];
            dz_q    <= (divisor == '0);
            ov_q    <= (dividend == {1'b1, {(WIDTH-1){1'b0}}}) &&
                       (divisor == '1);
            dq_q    <= dvd_mag_d;
            ds_q    <= dvs_mag_d;
            pr_q    <= '0;
            cnt_q   <= CW'(WIDTH);
            ready_q <= 1'b0;
            state_q <= CALC;
          end else begin
            ready_q <= 1'b1;
            state_q <= IDLE;
          end
        end
        CALC: begin
          pr_q  <= pr_d;
          dq_q  <= {dq_q[WIDTH-1:0], qbit_d};
          cnt_q <= cnt_q - CW'(1);
          if (cnt_q == CW'(1)) begin
            state_q <= SIGN;
          end
        end
        SIGN: begin
          if (dz_q) begin
            quo_q <= '1;
            rem_q <= dvd_q;
          end else begin
            quo_q <= quo_d;
            rem_q <= rem_d;
          end
          dz_o_q  <= dz_q;
          ov_o_q  <= ov_q;
          done_q  <= 1'b1;
          ready_q <= 1'b1;
          state_q <= DONE;
        end
        default: begin
          ready_q <= 1'b1;
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign ready       = ready_q;
  assign done        = done_q;
  assign quotient    = quo_q;
  assign remainder   = rem_q;
  assign div_by_zero = dz_o_q;
  assign overflow    = ov_o_q;

endmodule

// File: tb/tb_seq_signed_divider.sv
// Self-checking bench for seq_signed_divider:
// directed cases, ignored starts, mid-run reset, randomized ops.
module tb_seq_signed_divider;

  localparam int W   = 4;
  localparam int LAT = W + 2;

  logic         clk = 1'b0;
  logic         rst;
  logic         start;
  logic [W-1:0] dividend;
  logic [W-1:0] divisor;
  logic         ready;
  logic         done;
  logic [W-1:0] quotient;
  logic [W-1:0] remainder;
  logic         div_by_zero;
  logic         overflow;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  seq_signed_divider #(.WIDTH(W)) dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .dividend    (dividend),
    .divisor     (divisor),
    .ready       (ready),
    .done        (done),
    .quotient    (quotient),
    .remainder   (remainder),
    .div_by_zero (div_by_zero),
    .overflow    (overflow)
  );

  function automatic void model(
    input int a, input int b,
    output int q, output int r,
    output logic dz, output logic ov
  );
    dz = 1'b0;
    ov = 1'b0;
    if (b == 0) begin
      dz = 1'b1; q = -1; r = a;
    end else if (a == -(1 << (W-1)) && b == -1) begin
      ov = 1'b1; q = a; r = 0;
    end else begin
      q = a / b; r = a % b;
    end
  endfunction

  // Launch one op at the next negedge; lat counts edges incl. accept edge.
  task automatic run_div(
    input int a, input int b,
    output int lat,
    output logic [W-1:0] q, output logic [W-1:0] r,
    output logic dz, output logic ov
  );
    @(negedge clk);
    start    = 1'b1;
    dividend = W'(a);
    divisor  = W'(b);
    lat = 0;
    while (lat < 20) begin
      @(posedge clk); #1;
      lat++;
      if (lat == 1) start = 1'b0;
      if (done === 1'b1) break;
    end
    q  = quotient;
    r  = remainder;
    dz = div_by_zero;
    ov = overflow;
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b1; dividend = 4'd7; divisor = 4'd2;
    repeat (2) @(posedge clk);
    #1;
    tests++;
    if ({ready, done, quotient, remainder, div_by_zero, overflow} !==
        {1'b1, 1'b0, 4'd0, 4'd0, 1'b0, 1'b0}) begin
      fails++;
      $display("FAIL reset_state got r%b d%b q%h r%h z%b o%b want 1 0 0 0 0 0",
               ready, done, quotient, remainder, div_by_zero, overflow);
    end
    @(negedge clk);
    rst = 1'b0; start = 1'b0;
    @(posedge clk); #1;
    tests++;
    if (ready !== 1'b1 || done !== 1'b0) begin
      fails++;
      $display("FAIL reset_priority got ready=%b done=%b want 1 0",
               ready, done);
    end
  endtask

  task automatic test_directed();
    int da[6] = '{ 7, -7,  7, -7, -8, 5};
    int db[6] = '{ 2,  2, -2, -2, -1, 0};
    int eq[6] = '{ 3, -3, -3,  3, -8, -1};
    int er[6] = '{ 1, -1,  1, -1,  0, 5};
    logic ez[6] = '{0, 0, 0, 0, 0, 1};
    logic eo[6] = '{0, 0, 0, 0, 1, 0};
    int lat;
    logic [W-1:0] q, r;
    logic dz, ov;
    for (int i = 0; i < 6; i++) begin
      run_div(da[i], db[i], lat, q, r, dz, ov);
      tests++;
      if (lat !== LAT) begin
        fails++;
        $display("FAIL dir_latency %0d/%0d got %0d want %0d",
                 da[i], db[i], lat, LAT);
      end
      tests++;
      if ({q, r, dz, ov} !== {W'(eq[i]), W'(er[i]), ez[i], eo[i]}) begin
        fails++;
        $display("FAIL dir_result %0d/%0d got q=%h r=%h z=%b o=%b want q=%h r=%h z=%b o=%b",
                 da[i], db[i], q, r, dz, ov,
                 W'(eq[i]), W'(er[i]), ez[i], eo[i]);
      end
    end
  endtask

  task automatic test_back_to_back();
    int lat;
    logic [W-1:0] q, r;
    logic dz, ov;
    @(negedge clk);
    start = 1'b1; dividend = 4'd6; divisor = 4'd3;
    @(posedge clk); #1;
    start = 1'b0;
    tests++;
    if (ready !== 1'b0) begin
      fails++;
      $display("FAIL busy_ready got %b want 0", ready);
    end
    @(negedge clk);
    start = 1'b1; dividend = 4'd1; divisor = 4'd1;
    @(posedge clk); #1;
    start = 1'b0; dividend = 4'd0; divisor = 4'd0;
    lat = 2;
    while (lat < 20 && done !== 1'b1) begin
      @(posedge clk); #1;
      lat++;
    end
    tests++;
    if (lat !== LAT || quotient !== 4'd2 || remainder !== 4'd0) begin
      fails++;
      $display("FAIL ignore_start got lat=%0d q=%h r=%h want lat=%0d q=2 r=0",
               lat, quotient, remainder, LAT);
    end
    run_div(-8, 3, lat, q, r, dz, ov);
    tests++;
    if (lat !== LAT || q !== 4'b1110 || r !== 4'b1110 || dz || ov) begin
      fails++;
      $display("FAIL b2b_in_done got lat=%0d q=%h r=%h z=%b o=%b want lat=%0d q=e r=e 0 0",
               lat, q, r, dz, ov, LAT);
    end
  endtask

  task automatic test_reset_mid();
    int pulses;
    int lat;
    logic [W-1:0] q, r;
    logic dz, ov;
    @(negedge clk);
    start = 1'b1; dividend = 4'd7; divisor = 4'd2;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (2) begin
      @(posedge clk); #1;
    end
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk); #1;
    tests++;
    if ({ready, done, quotient, remainder, div_by_zero, overflow} !==
        {1'b1, 1'b0, 4'd0, 4'd0, 1'b0, 1'b0}) begin
      fails++;
      $display("FAIL mid_reset_state got r%b d%b q%h r%h z%b o%b want 1 0 0 0 0 0",
               ready, done, quotient, remainder, div_by_zero, overflow);
    end
    @(negedge clk);
    rst = 1'b0;
    pulses = 0;
    repeat (10) begin
      @(posedge clk); #1;
      if (done === 1'b1) pulses++;
    end
    tests++;
    if (pulses !== 0) begin
      fails++;
      $display("FAIL mid_reset_no_done got %0d pulses want 0", pulses);
    end
    run_div(3, 2, lat, q, r, dz, ov);
    tests++;
    if (lat !== LAT || q !== 4'd1 || r !== 4'd1 || dz || ov) begin
      fails++;
      $display("FAIL after_reset got lat=%0d q=%h r=%h want lat=%0d q=1 r=1",
               lat, q, r, LAT);
    end
  endtask

  task automatic test_random();
    int a, b, eq, er, lat;
    logic ez, eo;
    logic [W-1:0] q, r;
    logic dz, ov;
    for (int i = 0; i < 150; i++) begin
      a = int'($urandom_range(0, 15)) - 8;
      b = int'($urandom_range(0, 15)) - 8;
      model(a, b, eq, er, ez, eo);
      repeat ($urandom_range(0, 2)) @(negedge clk);
      run_div(a, b, lat, q, r, dz, ov);
      tests++;
      if (lat !== LAT || {q, r, dz, ov} !== {W'(eq), W'(er), ez, eo}) begin
        fails++;
        $display("FAIL rand %0d/%0d got lat=%0d q=%h r=%h z=%b o=%b want lat=%0d q=%h r=%h z=%b o=%b",
                 a, b, lat, q, r, dz, ov, LAT, W'(eq), W'(er), ez, eo);
      end
    end
    repeat (3) @(posedge clk);
    #1;
    tests++;
    if ({q, r, dz, ov} !== {quotient, remainder, div_by_zero, overflow}) begin
      fails++;
      $display("FAIL hold got q=%h r=%h want q=%h r=%h",
               quotient, remainder, q, r);
    end
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; dividend = '0; divisor = '0;
    test_reset();
    test_directed();
    test_back_to_back();
    test_reset_mid();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
